// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM pipeline register with two-entry skid buffer, valid/ready handshake and flush
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] val_rm,
    output logic [DEST_W-1:0] dest,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] val;
        logic [DEST_W-1:0] dest;
    } entry_t;
    state_t r_state, w_next;
    entry_t r_main, r_skid, w_in_ent;
    logic   w_in_fire, w_out_fire, w_ld_main, w_ld_skid, w_pop;
    assign w_in_ent   = '{wb: wb_en_in, mr: mem_r_en_in, mw: mem_w_en_in,
                          alu: alu_result_in, val: val_rm_in, dest: dest_in};
    assign in_ready   = r_state != TWO;
    assign out_valid  = r_state != EMPTY;
    assign occupancy  = r_state;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign wb_en      = r_main.wb & out_valid;
    assign mem_r_en   = r_main.mr & out_valid;
    assign mem_w_en   = r_main.mw & out_valid;
    assign alu_result = r_main.alu;
    assign val_rm     = r_main.val;
    assign dest       = r_main.dest;
    always_comb begin
        w_next    = r_state;
        w_ld_main = 1'b0;
        w_ld_skid = 1'b0;
        w_pop     = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_ld_main = w_in_fire;
                    w_next    = w_in_fire ? ONE : EMPTY;
                end
                ONE: begin
                    w_ld_main = w_in_fire & w_out_fire;
                    w_ld_skid = w_in_fire & ~w_out_fire;
                    w_next    = w_ld_skid ? TWO : (w_out_fire & ~w_in_fire) ? EMPTY : ONE;
                end
                TWO: begin
                    w_pop  = w_out_fire;
                    w_next = w_out_fire ? ONE : TWO;
                end
                default: w_next = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_main) r_main <= w_in_ent;
            else if (w_pop) r_main <= r_skid;
            if (w_ld_skid) r_skid <= w_in_ent;
        end
    end
endmodule
